// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl.
// master = surrounding environment (producer, consumer, RAM); slave = the controller.
interface ram_fifo_ctrl_if #(
  parameter int d_width = 8,
  parameter int a_width = 4
);
  logic               wr_valid;
  logic               wr_ready;
  logic [d_width-1:0] wr_data;
  logic               rd_valid;
  logic               rd_ready;
  logic [d_width-1:0] rd_data;
  logic               ram_we;
  logic [a_width-1:0] ram_address_w;
  logic [d_width-1:0] ram_data_in;
  logic [a_width-1:0] ram_address_r;
  logic [d_width-1:0] ram_data_out;

  modport master (
    output wr_valid, wr_data, rd_ready, ram_data_out,
    input  wr_ready, rd_valid, rd_data, ram_we, ram_address_w, ram_data_in, ram_address_r
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_data_out,
    output wr_ready, rd_valid, rd_data, ram_we, ram_address_w, ram_data_in, ram_address_r
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a simple dual-port RAM with a
// one-cycle registered read; a 2-entry output buffer hides the read latency.
module ram_fifo_ctrl #(
  parameter int d_width = 8,
  parameter int a_width = 4
) (
  input  logic             clk,
  input  logic             nrst,
  ram_fifo_ctrl_if.slave   bus,
  output logic [a_width+1:0] count
);

  localparam int DEPTH = 2 ** a_width;
  localparam logic [a_width:0] FULL_CNT = (a_width+1)'(DEPTH);

  logic [a_width-1:0] wptr_q, wptr_d;
  logic [a_width-1:0] rptr_q, rptr_d;
  logic [a_width:0]   ram_cnt_q, ram_cnt_d;
  logic               pend_q, pend_d;
  logic [1:0]         occ_q, occ_d;
  logic [d_width-1:0] buf_q [2];
  logic [d_width-1:0] buf_d [2];
  logic               rd_valid_q;
  logic [a_width+1:0] count_q;

  logic               wr_ready_s;
  logic               push_s;
  logic               pop_s;
  logic               fetch_s;
  logic [2:0]         room_s;
  logic [1:0]         slot_s;

  // Handshake decode and next-state computation.
  always_comb begin
    wr_ready_s = (ram_cnt_q != FULL_CNT);
    // Gated with nrst so the RAM is never written while reset is asserted.
    push_s     = bus.wr_valid & wr_ready_s & nrst;
    pop_s      = (occ_q != 2'd0) & bus.rd_ready;
    room_s     = 3'(occ_q) + 3'(pend_q) - 3'(pop_s);
    fetch_s    = (ram_cnt_q != '0) & (room_s < 3'd2);
    slot_s     = occ_q - 2'(pop_s);

    wptr_d     = push_s  ? wptr_q + a_width'(1) : wptr_q;
    rptr_d     = fetch_s ? rptr_q + a_width'(1) : rptr_q;
    ram_cnt_d  = ram_cnt_q + (a_width+1)'(push_s) - (a_width+1)'(fetch_s);
    pend_d     = fetch_s;
    occ_d      = room_s[1:0];

    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    if (pop_s) begin
      buf_d[0] = buf_q[1];
    end else begin
      buf_d[0] = buf_q[0];
    end
    // Arriving RAM word lands in the first free slot after this cycle's pop.
    if (pend_q) begin
      case (slot_s)
        2'd0:    buf_d[0] = bus.ram_data_out;
        2'd1:    buf_d[1] = bus.ram_data_out;
        default: buf_d[1] = buf_q[1];
      endcase
    end else begin
      buf_d[1] = buf_d[1];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      pend_q     <= 1'b0;
      occ_q      <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      pend_q     <= pend_d;
      occ_q      <= occ_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      rd_valid_q <= (occ_d != 2'd0);
      count_q    <= (a_width+2)'(ram_cnt_d) + (a_width+2)'(pend_d) + (a_width+2)'(occ_d);
    end
  end

  assign bus.wr_ready      = wr_ready_s;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = buf_q[0];
  assign bus.ram_we        = push_s;
  assign bus.ram_address_w = wptr_q;
  assign bus.ram_data_in   = bus.wr_data;
  assign bus.ram_address_r = rptr_q;
  assign count             = count_q;

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Controller that turns one `sync_ram_simple_dual` instance into a first-word-fall-through FIFO with valid/ready handshakes on both sides. It owns the RAM's write port (`we`, `address_w`, `data_in`) and read address (`address_r`), and absorbs the RAM's one-cycle registered read latency with a 2-entry output buffer. It sits between a streaming producer and consumer in the DE10-Nano datapath, and the RAM instance sits next to it at the same hierarchy level.

## Interface
- `d_width`, 8, data word width; must match the RAM instance.
- `a_width`, 4, RAM address width; RAM depth `DEPTH = 2**a_width`.

- `clk`  in  1  single clock; all state is on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  producer has a word.
- `wr_ready`  out  1  controller accepts a word.
- `wr_data`  in  d_width  producer word.
- `rd_valid`  out  1  head word is available on `rd_data`.
- `rd_ready`  in  1  consumer takes the head word.
- `rd_data`  out  d_width  head word, which is buffer entry 0.
- `ram_we`  out  1  goes to RAM `we`.
- `ram_address_w`  out  a_width  goes to RAM `address_w`.
- `ram_data_in`  out  d_width  goes to RAM `data_in`.
- `ram_address_r`  out  a_width  goes to RAM `address_r`.
- `ram_data_out`  in  d_width  comes from RAM `data_out`; registered, 1-cycle latency.
- `count`  out  a_width+2  total words held: `ram_cnt + pend + occ`.

## Operation
- State:
  - `wptr`, `rptr` (a_width bits each; wrap modulo DEPTH).
  - `ram_cnt` (0..DEPTH): words written to the RAM and not yet fetched.
  - `pend` (1 bit): a RAM read is in flight.
  - Output buffer of 2 entries with `occ` (0..2).
- Write accept: `push = wr_valid & wr_ready`, with `wr_ready = (ram_cnt != DEPTH)`.
  - On `push`: `ram_we = 1`, `ram_address_w = wptr`, `ram_data_in = wr_data`, and `wptr` increments.
  - `ram_we` is driven as `push` exactly. The RAM is never written when `push` is low.
- Pop: `pop = rd_valid & rd_ready`, with `rd_valid = (occ != 0)`. On `pop`, entry 1 shifts into entry 0.
- Fetch: `fetch = (ram_cnt != 0) & (occ + pend - pop < 2)`.
  - `ram_address_r = rptr` at all times.
  - On `fetch`: `rptr` increments and `pend` is set for the next cycle.
  - On a cycle without `fetch`, `pend` is cleared.
- Arrival: when `pend = 1`, `ram_data_out` is written into buffer slot `occ - pop`, the first free slot after the pop.
- `ram_cnt` next value = `ram_cnt + push - fetch`. Push and fetch can occur in the same cycle.
- `occ` next value = `occ + pend - pop`. It never exceeds 2, which the fetch rule guarantees.
- Ordering: words leave on `rd_data` in exactly the order they were accepted.
- Hazard-free by construction:
  - The RAM is never read at an address being written in the same cycle with unfetched data, because `push` at `wptr == rptr` requires `ram_cnt = 0`, and in that case no fetch occurs.
  - A word written at edge E is fetchable in the cycle after E.
- Reset (`nrst` low, at any time, including mid-transfer):
  - Pointers, `ram_cnt`, `pend`, `occ` and the buffer are set to 0.
  - Outputs during and after reset: `rd_valid` 0, `rd_data` 0, `wr_ready` 1, `ram_we` 0, `ram_address_w` 0, `ram_address_r` 0, `ram_data_in` = `wr_data`, `count` 0.
  - RAM contents are not cleared; stale words are never delivered.
  - An in-flight read is discarded.

## Timing
- Write-to-read latency when the FIFO is empty: word accepted at edge E0 (E0 is the rising edge that samples `push`):
  - fetch in the cycle after E0;
  - RAM output valid after E1;
  - `rd_valid = 1` after E2.
- Throughput: 1 word/cycle sustained when push and pop are both continuous, with `occ = 1` and `pend = 1` in steady state.
- Capacity: DEPTH + 2 words.
  - `wr_ready` falls only when `ram_cnt = DEPTH`.
  - `wr_ready` is combinational from registered `ram_cnt` and does not depend on `rd_ready`.
- `rd_valid` and `rd_data` are driven from registers only. `rd_data` is stable while `rd_valid & !rd_ready`.
- `count` is registered-derived, with no combinational path from `wr_valid` or `rd_ready`.

## Test plan
- Reset values: hold `nrst` low for 3 cycles, then release → `rd_valid` 0, `wr_ready` 1, `count` 0, `ram_we` never 1.
- Latency: with `a_width` = 4 and the FIFO empty, push 0xA5 at E0 → `ram_we` = 1 with `ram_address_w` = 0 in that cycle; `rd_valid` = 1 with `rd_data` = 0xA5 after E2; `count` = 1 throughout.
- Fill: with `rd_ready` = 0, push 0x00..0x11 (18 words) → `wr_ready` = 0 after the 18th accept; `count` = 18; the 19th `wr_valid` is not accepted.
- Drain with wrap: from full, set `rd_ready` = 1 and push continuously → output sequence 0x00, 0x01, … with no gaps; pointers wrap 15→0 correctly over 40 words.
- Random stall: random `wr_valid`/`rd_ready` over 2000 cycles → output exactly matches the input order, `count` matches the scoreboard, and `rd_data` holds steady under backpressure.
- Mid-operation reset: assert `nrst` low while `pend` = 1 and `occ` = 2 → all outputs return to reset values; after release, only new words are delivered.
